pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 121 ++++++++++++
 tb/tb_pc_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Instruction-fetch program counter sequencer: IDLE -> FETCH -> EXEC loop,
// with next-PC resolution for JR, Jump/Jal and conditional branches.
module pc_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        Jump,
    input  logic        Jal,
    input  logic        JR,
    input  logic        BranchEQ,
    input  logic        BranchNE,
    input  logic        Zero,
    input  logic [25:0] JumpField,
    input  logic [15:0] BranchOffset,
    input  logic [31:0] RegJR,
    input  logic        Stall,
    input  logic        ImemReady,
    input  logic [31:0] ImemData,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    output logic [31:0] PC,
    output logic [31:0] Instruction,
    output logic        InstrValid,
    output logic [31:0] ReturnAddr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    state_t      stateReg, stateNext;
    logic [31:0] pcReg, pcNext;
    logic [31:0] instrReg, instrNext;

    logic [31:0] pcPlus4;
    logic [31:0] branchOffsetExt;
    logic [31:0] branchTarget;
    logic [31:0] jumpTarget;
    logic [31:0] jrTarget;
    logic        branchTaken;
    logic [31:0] targetPc;

    // Target arithmetic is plain 32-bit addition, so wrap-around is implicit.
    assign pcPlus4         = pcReg + 32'd4;
    assign branchOffsetExt = {{14{BranchOffset[15]}}, BranchOffset, 2'b00};
    assign branchTarget    = pcPlus4 + branchOffsetExt;
    assign jumpTarget      = {pcPlus4[31:28], JumpField, 2'b00};
    assign jrTarget        = RegJR & 32'hFFFF_FFFC;
    assign branchTaken     = (BranchEQ & Zero) | (BranchNE & ~Zero);

    always_comb begin
        targetPc = pcPlus4;
        if (JR)
            targetPc = jrTarget;
        else if (Jump || Jal)
            targetPc = jumpTarget;
        else if (branchTaken)
            targetPc = branchTarget;
    end

    // Reset wins over everything, so a fetch completing in the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg <= IDLE;
            pcReg    <= RESET_PC;
            instrReg <= 32'h0000_0000;
        end else begin
            stateReg <= stateNext;
            pcReg    <= pcNext;
            instrReg <= instrNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        pcNext    = pcReg;
        instrNext = instrReg;
        case (stateReg)
            IDLE: begin
                stateNext = FETCH;
            end
            FETCH: begin
                if (ImemReady) begin
                    instrNext = ImemData;
                    stateNext = EXEC;
                end
            end
            EXEC: begin
                if (!Stall) begin
                    pcNext    = targetPc;
                    stateNext = FETCH;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_comb begin
        ImemReq    = 1'b0;
        InstrValid = 1'b0;
        case (stateReg)
            FETCH:   ImemReq    = 1'b1;
            EXEC:    InstrValid = 1'b1;
            default: begin
                ImemReq    = 1'b0;
                InstrValid = 1'b0;
            end
        endcase
    end

    assign PC          = pcReg;
    assign ImemAddr    = pcReg;
    assign Instruction = instrReg;
    assign ReturnAddr  = pcPlus4;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table of next-PC cases through
// a scoreboard queue, plus hand sequences for reset, fetch wait and stall.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        Jump, Jal, JR, BranchEQ, BranchNE, Zero;
    logic [25:0] JumpField;
    logic [15:0] BranchOffset;
    logic [31:0] RegJR;
    logic        Stall;
    logic        ImemReady;
    logic [31:0] ImemData;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic        InstrValid;
    logic [31:0] ReturnAddr;

    int checkCount = 0;
    int errorCount = 0;

    logic [31:0] expQueue[$];

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .reset(reset),
        .Jump(Jump), .Jal(Jal), .JR(JR), .BranchEQ(BranchEQ), .BranchNE(BranchNE),
        .Zero(Zero), .JumpField(JumpField), .BranchOffset(BranchOffset), .RegJR(RegJR),
        .Stall(Stall), .ImemReady(ImemReady), .ImemData(ImemData),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .PC(PC), .Instruction(Instruction),
        .InstrValid(InstrValid), .ReturnAddr(ReturnAddr)
    );

    typedef struct {
        string       name;
        logic [31:0] pcStart;
        logic        jump, jal, jr, beq, bne, zero;
        logic [25:0] jumpField;
        logic [15:0] offset;
        logic [31:0] regJr;
        logic [31:0] expNext;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearCtrl();
        Jump = 0; Jal = 0; JR = 0; BranchEQ = 0; BranchNE = 0; Zero = 0;
        JumpField = '0; BranchOffset = '0; RegJR = '0; Stall = 0;
    endtask

    task automatic waitValid(input string name);
        int n = 0;
        while (!InstrValid && n < 20) begin
            step();
            n++;
        end
        if (!InstrValid) begin
            checkCount++;
            errorCount++;
            $display("FAIL %s: InstrValid timeout got 0 expected 1", name);
        end
    endtask

    task automatic gotoPc(input logic [31:0] target);
        waitValid("gotoPc_pre");
        clearCtrl();
        JR = 1; RegJR = target;
        step();
        clearCtrl();
        waitValid("gotoPc_post");
        check("gotoPc", PC, target);
    endtask

    initial begin
        vecs[0] = '{"beq_taken",   32'h0040_0010, 0,0,0,1,0,1, 26'h0,       16'hFFFC, 32'h0, 32'h0040_0004};
        vecs[1] = '{"beq_not",     32'h0040_0010, 0,0,0,1,0,0, 26'h0,       16'hFFFC, 32'h0, 32'h0040_0014};
        vecs[2] = '{"jal",         32'h0040_0020, 0,1,0,0,0,0, 26'h0100008, 16'h0,    32'h0, 32'h0040_0020};
        vecs[3] = '{"jr_over_j",   32'h0040_0000, 1,0,1,0,0,0, 26'h0000123, 16'h0,    32'h0040_0103, 32'h0040_0100};
        vecs[4] = '{"bne_taken",   32'h0040_0040, 0,0,0,0,1,0, 26'h0,       16'h0003, 32'h0, 32'h0040_0050};
        vecs[5] = '{"bne_not",     32'h0040_0040, 0,0,0,0,1,1, 26'h0,       16'h0003, 32'h0, 32'h0040_0044};
        vecs[6] = '{"pc4_wrap",    32'hFFFF_FFFC, 0,0,0,0,0,0, 26'h0,       16'h0,    32'h0, 32'h0000_0000};
        vecs[7] = '{"jump_region", 32'hF000_0010, 1,0,0,0,0,0, 26'h3FFFFFF, 16'h0,    32'h0, 32'hFFFF_FFFC};
        vecs[8] = '{"branch_wrap", 32'hFFFF_FFF0, 0,0,0,1,0,1, 26'h0,       16'h0004, 32'h0, 32'h0000_0004};
        vecs[9] = '{"j_over_beq",  32'h0040_0000, 1,0,0,1,0,1, 26'h0000040, 16'h0010, 32'h0, 32'h0000_0100};

        clearCtrl();
        reset = 1; ImemReady = 1; ImemData = 32'h1234_5678;
        step();
        step();
        check("rst_pc", PC, 32'h0040_0000);
        check("rst_instr", Instruction, 32'h0);
        check("rst_req", {31'b0, ImemReq}, 32'h0);
        check("rst_valid", {31'b0, InstrValid}, 32'h0);
        check("rst_retaddr", ReturnAddr, 32'h0040_0004);
        reset = 0;

        // Free-running fetch: IDLE once, then FETCH/EXEC alternating.
        begin
            logic        expReq[6]   = '{1, 0, 1, 0, 1, 0};
            logic        expVal[6]   = '{0, 1, 0, 1, 0, 1};
            logic [31:0] expPc[6]    = '{32'h0040_0000, 32'h0040_0000, 32'h0040_0004,
                                         32'h0040_0004, 32'h0040_0008, 32'h0040_0008};
            for (int i = 0; i < 6; i++) begin
                step();
                check("seq_req", {31'b0, ImemReq}, {31'b0, expReq[i]});
                check("seq_valid", {31'b0, InstrValid}, {31'b0, expVal[i]});
                check("seq_pc", PC, expPc[i]);
                check("seq_addr", ImemAddr, expPc[i]);
                $display("seq cycle %0d pc=0x%08h req=%0b valid=%0b", i, PC, ImemReq, InstrValid);
            end
            check("seq_instr", Instruction, 32'h1234_5678);
        end

        // Table-driven next-PC cases through the scoreboard.
        for (int v = 0; v < 10; v++) begin
            gotoPc(vecs[v].pcStart);
            check({vecs[v].name, "_retaddr"}, ReturnAddr, vecs[v].pcStart + 32'd4);
            Jump = vecs[v].jump; Jal = vecs[v].jal; JR = vecs[v].jr;
            BranchEQ = vecs[v].beq; BranchNE = vecs[v].bne; Zero = vecs[v].zero;
            JumpField = vecs[v].jumpField; BranchOffset = vecs[v].offset; RegJR = vecs[v].regJr;
            expQueue.push_back(vecs[v].expNext);
            step();
            clearCtrl();
            check({vecs[v].name, "_fetch_req"}, {31'b0, ImemReq}, 32'h1);
            waitValid(vecs[v].name);
            if (expQueue.size() > 0) begin
                logic [31:0] e;
                e = expQueue.pop_front();
                check({vecs[v].name, "_nextpc"}, PC, e);
                $display("vec %s start=0x%08h next=0x%08h exp=0x%08h", vecs[v].name,
                         vecs[v].pcStart, PC, e);
            end
        end

        // Slow memory: ready low 3 FETCH cycles, then a stall of 2 EXEC cycles.
        gotoPc(32'h0040_0200);
        ImemReady = 0;
        step();
        for (int i = 0; i < 4; i++) begin
            check("wait_req", {31'b0, ImemReq}, 32'h1);
            check("wait_novalid", {31'b0, InstrValid}, 32'h0);
            if (i == 3) begin
                ImemReady = 1;
                ImemData  = 32'h8C08_0004;
            end
            step();
        end
        check("wait_instr", Instruction, 32'h8C08_0004);
        check("wait_valid", {31'b0, InstrValid}, 32'h1);
        check("wait_pc", PC, 32'h0040_0204);
        $display("slow fetch instr=0x%08h pc=0x%08h", Instruction, PC);
        Stall = 1; Jump = 1; JumpField = 26'h0000777; ImemData = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_valid", {31'b0, InstrValid}, 32'h1);
            check("stall_req", {31'b0, ImemReq}, 32'h0);
            check("stall_pc", PC, 32'h0040_0204);
            check("stall_instr", Instruction, 32'h8C08_0004);
        end
        clearCtrl();
        step();
        check("unstall_valid", {31'b0, InstrValid}, 32'h0);
        check("unstall_pc", PC, 32'h0040_0208);
        $display("stall release pc=0x%08h", PC);

        // Reset arriving on the cycle a fetch completes.
        waitValid("pre_rst");
        step();
        check("pre_rst_req", {31'b0, ImemReq}, 32'h1);
        ImemReady = 1; ImemData = 32'hCAFE_F00D; reset = 1;
        step();
        reset = 0;
        check("midrst_instr", Instruction, 32'h0);
        check("midrst_pc", PC, 32'h0040_0000);
        check("midrst_req", {31'b0, ImemReq}, 32'h0);
        check("midrst_valid", {31'b0, InstrValid}, 32'h0);
        step();
        check("postrst_req", {31'b0, ImemReq}, 32'h1);
        $display("mid-fetch reset instr=0x%08h pc=0x%08h", Instruction, PC);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
